// File: rtl/tile_sequencer.sv
// tile_sequencer: walks C = A*W as a stream of tile descriptors.
// Dimensions M/K/N are software-programmed while idle. A start pulse then
// issues tiles in m-outer, n-middle, k-inner order over a valid/ready handshake.
module tile_sequencer #(
  parameter int SYS_ROWS = 16,
  parameter int SYS_COLS = 16,
  parameter int M_TILE   = 128,
  parameter int DIM_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [1:0]                   cfg_addr,
  input  logic [DIM_W-1:0]             cfg_wdata,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         tile_ready,
  output logic                         tile_valid,
  output logic [DIM_W-1:0]             tile_m_base,
  output logic [DIM_W-1:0]             tile_k_base,
  output logic [DIM_W-1:0]             tile_n_base,
  output logic [$clog2(M_TILE):0]      tile_m_len,
  output logic [$clog2(SYS_ROWS):0]    tile_k_len,
  output logic [$clog2(SYS_COLS):0]    tile_n_len,
  output logic                         tile_first_k,
  output logic                         tile_last_k,
  output logic                         tile_last,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err
);
  localparam int MLW = $clog2(M_TILE) + 1;
  localparam int KLW = $clog2(SYS_ROWS) + 1;
  localparam int NLW = $clog2(SYS_COLS) + 1;
  // Extended steps: the end-of-dimension test must not wrap at 2^DIM_W-1.
  localparam logic [DIM_W:0]   M_STEP_X = (DIM_W+1)'(M_TILE);
  localparam logic [DIM_W:0]   K_STEP_X = (DIM_W+1)'(SYS_ROWS);
  localparam logic [DIM_W:0]   N_STEP_X = (DIM_W+1)'(SYS_COLS);
  localparam logic [DIM_W-1:0] M_STEP   = DIM_W'(M_TILE);
  localparam logic [DIM_W-1:0] K_STEP   = DIM_W'(SYS_ROWS);
  localparam logic [DIM_W-1:0] N_STEP   = DIM_W'(SYS_COLS);

  typedef enum logic {IDLE, ISSUE} state_t;

  typedef struct packed {
    logic [DIM_W-1:0] m_base;
    logic [DIM_W-1:0] k_base;
    logic [DIM_W-1:0] n_base;
    logic [MLW-1:0]   m_len;
    logic [KLW-1:0]   k_len;
    logic [NLW-1:0]   n_len;
    logic             first_k;
    logic             last_k;
    logic             last_n;
    logic             last_m;
    logic             last;
  } desc_t;

  state_t           state_q, state_d;
  desc_t            desc_q, desc_d;
  logic             valid_q, valid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [DIM_W-1:0] dim_m, dim_k, dim_n;
  logic [DIM_W-1:0] mb_n, kb_n, nb_n;
  logic             dims_ok;

  // Full descriptor (lengths and loop-end flags) for a given tile origin.
  function automatic desc_t make_desc(input logic [DIM_W-1:0] mb, kb, nb, dm, dk, dn);
    desc_t            d;
    logic [DIM_W-1:0] rm, rk, rn;
    rm        = dm - mb;
    rk        = dk - kb;
    rn        = dn - nb;
    d.m_base  = mb;
    d.k_base  = kb;
    d.n_base  = nb;
    d.m_len   = (rm >= M_STEP) ? MLW'(M_TILE)   : rm[MLW-1:0];
    d.k_len   = (rk >= K_STEP) ? KLW'(SYS_ROWS) : rk[KLW-1:0];
    d.n_len   = (rn >= N_STEP) ? NLW'(SYS_COLS) : rn[NLW-1:0];
    d.first_k = (kb == '0);
    d.last_k  = ({1'b0, kb} + K_STEP_X) >= {1'b0, dk};
    d.last_n  = ({1'b0, nb} + N_STEP_X) >= {1'b0, dn};
    d.last_m  = ({1'b0, mb} + M_STEP_X) >= {1'b0, dm};
    d.last    = d.last_k & d.last_n & d.last_m;
    return d;
  endfunction

  assign dims_ok = (dim_m != '0) && (dim_k != '0) && (dim_n != '0);

  // Dimension registers: writable only while idle, address 3 is a no-op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dim_m <= '0;
      dim_k <= '0;
      dim_n <= '0;
    end else if (cfg_we && state_q == IDLE) begin
      case (cfg_addr)
        2'd0:    dim_m <= cfg_wdata;
        2'd1:    dim_k <= cfg_wdata;
        2'd2:    dim_n <= cfg_wdata;
        default: ;
      endcase
    end
  end

  // Next tile origin, k fastest then n then m. A base is only stepped when it
  // is not the last one, so the DIM_W-bit add never wraps.
  always_comb begin
    mb_n = desc_q.m_base;
    kb_n = desc_q.k_base + K_STEP;
    nb_n = desc_q.n_base;
    if (desc_q.last_k) begin
      kb_n = '0;
      nb_n = desc_q.n_base + N_STEP;
      if (desc_q.last_n) begin
        nb_n = '0;
        mb_n = desc_q.m_base + M_STEP;
      end
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d = state_q;
    desc_d  = desc_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (dims_ok) begin
            state_d = ISSUE;
            desc_d  = make_desc('0, '0, '0, dim_m, dim_k, dim_n);
            valid_d = 1'b1;
            busy_d  = 1'b1;
            err_d   = 1'b0;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (valid_q && tile_ready) begin
          if (desc_q.last) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            desc_d  = make_desc(mb_n, kb_n, nb_n, dim_m, dim_k, dim_n);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      desc_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign tile_valid   = valid_q;
  assign tile_m_base  = desc_q.m_base;
  assign tile_k_base  = desc_q.k_base;
  assign tile_n_base  = desc_q.n_base;
  assign tile_m_len   = desc_q.m_len;
  assign tile_k_len   = desc_q.k_len;
  assign tile_n_len   = desc_q.n_len;
  assign tile_first_k = desc_q.first_k;
  assign tile_last_k  = desc_q.last_k;
  assign tile_last    = desc_q.last;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_err      = err_q;
endmodule

// File: tb/tb_tile_sequencer.sv
// Bench for tile_sequencer: table of configurations plus random configs,
// each checked tile by tile against a nested-loop reference, and hand
// sequences for config error, abort and mid-run reset.
module tb_tile_sequencer;
  logic        clk = 1'b0;
  logic        rst, cfg_we, start, abort, tile_ready;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        tile_valid, tile_first_k, tile_last_k, tile_last, busy, done, cfg_err;
  logic [15:0] tile_m_base, tile_k_base, tile_n_base;
  logic [7:0]  tile_m_len;
  logic [4:0]  tile_k_len, tile_n_len;

  int total = 0;
  int bad   = 0;

  tile_sequencer dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .abort(abort), .tile_ready(tile_ready), .tile_valid(tile_valid),
    .tile_m_base(tile_m_base), .tile_k_base(tile_k_base), .tile_n_base(tile_n_base),
    .tile_m_len(tile_m_len), .tile_k_len(tile_k_len), .tile_n_len(tile_n_len),
    .tile_first_k(tile_first_k), .tile_last_k(tile_last_k), .tile_last(tile_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [15:0] mb, kb, nb;
    logic [7:0]  ml;
    logic [4:0]  kl, nl;
    logic        fk, lk, ls;
  } desc_t;

  typedef struct {
    int m, k, n, mode, cnt, ml, kl, nl;
  } vec_t;

  desc_t q[$];
  desc_t last_seen;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic desc_t dut_desc();
    return {tile_m_base, tile_k_base, tile_n_base, tile_m_len, tile_k_len, tile_n_len,
            tile_first_k, tile_last_k, tile_last};
  endfunction

  function automatic logic [127:0] all_out();
    return 128'({tile_valid, tile_m_base, tile_k_base, tile_n_base, tile_m_len, tile_k_len,
                 tile_n_len, tile_first_k, tile_last_k, tile_last, busy, done, cfg_err});
  endfunction

  // Reference tile list: plain nested loops over the product.
  task automatic build(input int M, input int K, input int N);
    q.delete();
    for (int m = 0; m < M; m += 128)
      for (int n = 0; n < N; n += 16)
        for (int k = 0; k < K; k += 16) begin
          desc_t d;
          d.mb = 16'(m);
          d.kb = 16'(k);
          d.nb = 16'(n);
          d.ml = 8'((M - m < 128) ? M - m : 128);
          d.kl = 5'((K - k < 16) ? K - k : 16);
          d.nl = 5'((N - n < 16) ? N - n : 16);
          d.fk = (k == 0);
          d.lk = (k + 16 >= K);
          d.ls = d.lk && (n + 16 >= N) && (m + 128 >= M);
          q.push_back(d);
        end
  endtask

  task automatic wr(input logic [1:0] a, input int v);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = 16'(v);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic cfg(input int M, input int K, input int N);
    wr(2'd0, M); wr(2'd1, K); wr(2'd2, N);
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low 5 cycles on 3rd tile.
  task automatic run(input int M, input int K, input int N, input int mode, output int cnt);
    desc_t prev;
    bit    stalled = 1'b0;
    bit    r;
    int    stall = 0;
    int    cyc = 0;
    int    limit;
    build(M, K, N);
    limit = q.size() * 4 + 50;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_on_start", 128'(busy), 128'(1));
    check("err_cleared", 128'(cfg_err), 128'(0));
    cnt = 0;
    while (cnt < q.size() && cyc < limit) begin
      check("valid_held", 128'(tile_valid), 128'(1));
      if (!tile_valid) break;
      if (stalled) check("stall_stable", 128'(dut_desc()), 128'(prev));
      case (mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 2) != 0);
        default: r = !(cnt == 2 && stall < 5);
      endcase
      if (!r && mode == 2) stall++;
      tile_ready = r;
      if (r) begin
        check($sformatf("desc%0d", cnt), 128'(dut_desc()), 128'(q[cnt]));
        last_seen = dut_desc();
        cnt++;
      end
      prev    = dut_desc();
      stalled = !r;
      @(negedge clk);
      cyc++;
    end
    tile_ready = 1'b0;
    check("desc_count", 128'(cnt), 128'(q.size()));
    check("done_pulse", 128'({done, busy, tile_valid}), 128'(3'b100));
  endtask

  initial begin
    vec_t tbl[7];
    int   c;
    bit   seen;
    tbl[0] = '{16, 16, 16, 0, 1, 16, 16, 16};
    tbl[1] = '{130, 20, 17, 0, 8, 2, 4, 1};
    tbl[2] = '{130, 20, 17, 2, 8, 2, 4, 1};
    tbl[3] = '{1, 1, 1, 1, 1, 1, 1, 1};
    tbl[4] = '{129, 33, 32, 1, 12, 1, 1, 16};
    tbl[5] = '{65535, 16, 16, 0, 512, 127, 16, 16};
    tbl[6] = '{1, 65535, 1, 0, 4096, 1, 15, 1};

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    start = 1'b0; abort = 1'b0; tile_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", all_out(), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", all_out(), 128'(0));

    foreach (tbl[i]) begin
      cfg(tbl[i].m, tbl[i].k, tbl[i].n);
      run(tbl[i].m, tbl[i].k, tbl[i].n, tbl[i].mode, c);
      check($sformatf("tbl%0d_count", i), 128'(c), 128'(tbl[i].cnt));
      check($sformatf("tbl%0d_lens", i), 128'({last_seen.ml, last_seen.kl, last_seen.nl, last_seen.ls}),
            128'({8'(tbl[i].ml), 5'(tbl[i].kl), 5'(tbl[i].nl), 1'b1}));
    end

    for (int i = 0; i < 12; i++) begin
      int m, k, n;
      m = $urandom_range(1, 300);
      k = $urandom_range(1, 50);
      n = $urandom_range(1, 50);
      cfg(m, k, n);
      run(m, k, n, 1, c);
    end

    // Zero K rejected, then accepted after fixing it; second run starts on done.
    cfg(16, 0, 16);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cfg_err_set", 128'({cfg_err, busy, tile_valid}), 128'(3'b100));
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= tile_valid | busy;
    end
    check("no_issue_on_err", 128'(seen), 128'(0));
    wr(2'd1, 16);
    run(16, 16, 16, 0, c);
    run(16, 16, 16, 0, c);
    check("back_to_back", 128'(c), 128'(1));

    // Abort together with a handshake on the 2nd tile; busy-time write dropped.
    cfg(130, 20, 17);
    build(130, 20, 17);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tile_ready = 1'b1;
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 16'd1;
    @(negedge clk);
    cfg_we = 1'b0;
    check("abort_desc1", 128'(dut_desc()), 128'(q[1]));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tile_ready = 1'b0;
    check("abort_idle", 128'({tile_valid, busy, done}), 128'(0));
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= done;
    end
    check("abort_no_done", 128'(seen), 128'(0));
    run(130, 20, 17, 0, c);
    check("dropped_write", 128'(c), 128'(8));

    // Reset during the 4th tile clears everything including dimensions.
    cfg(130, 20, 17);
    build(130, 20, 17);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tile_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_desc3", 128'(dut_desc()), 128'(q[3]));
    tile_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check("rst_async", all_out(), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    check("rst_outputs", all_out(), 128'(0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_dims_cleared", 128'({cfg_err, busy, tile_valid}), 128'(3'b100));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
